// File: rtl/reg_file.sv
// 32 x WIDTH register file with X31 as the zero register.
// Build option: define REG_FILE_BYPASS_EN for write-through forwarding.
module reg_file #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [4:0]       write_register,
  input  logic [WIDTH-1:0] write_data,
  input  logic [4:0]       read_register1,
  input  logic [4:0]       read_register2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2
);

  localparam logic [4:0] XZR = 5'd31;

  logic [30:0]      sel;
  logic [WIDTH-1:0] regs [31];
  logic [WIDTH-1:0] view [32];

  // one-hot write select; the X31 line is never generated
  always_comb begin
    sel = '0;
    for (int i = 0; i < 31; i++) begin
      sel[i] = reg_write && (write_register == 5'(i));
    end
  end

  for (genvar g = 0; g < 31; g++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        regs[g] <= '0;
      end else if (sel[g]) begin
        regs[g] <= write_data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 31; i++) begin
      view[i] = regs[i];
    end
    view[31] = '0;
  end

`ifdef REG_FILE_BYPASS_EN
  logic wr_live;
  logic byp1;
  logic byp2;

  // forwarding is suppressed during reset so outputs stay at zero
  assign wr_live = reg_write && !reset
                   && (write_register != XZR);
  assign byp1 = wr_live
                && (write_register == read_register1);
  assign byp2 = wr_live
                && (write_register == read_register2);

  assign read_data1 = byp1 ? write_data
                           : view[read_register1];
  assign read_data2 = byp2 ? write_data
                           : view[read_register2];
`else
  logic unused_xzr;

  assign unused_xzr = ^XZR;
  assign read_data1 = view[read_register1];
  assign read_data2 = view[read_register2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// Expected read values come from a bench-side register model.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [63:0] write_data;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic [63:0] read_data1;
  logic [63:0] read_data2;

  int errors;
  int checks;

  logic [63:0] model [32];
  logic [63:0] sb [$];

  reg_file #(.WIDTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .read_data1     (read_data1),
    .read_data2     (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic model_wr(input logic [4:0] a,
                          input logic [63:0] d);
    if (a != 5'd31) model[a] = d;
  endtask

  task automatic cmp(input string tag,
                     input logic [63:0] obs);
    logic [63:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic push_pair(input logic [4:0] a,
                           input logic [4:0] b);
    sb.push_back(model[a]);
    sb.push_back(model[b]);
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] a,
                    input logic [4:0] b);
    @(negedge clk);
    read_register1 = a;
    read_register2 = b;
    push_pair(a, b);
    #1;
    cmp({tag, "_p1"}, read_data1);
    cmp({tag, "_p2"}, read_data2);
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [63:0] d);
    @(negedge clk);
    reg_write      = 1'b1;
    write_register = a;
    write_data     = d;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    if (!reset) model_wr(a, d);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b1;
    reg_write      = 1'b0;
    write_register = '0;
    write_data     = '0;
    read_register1 = '0;
    read_register2 = '0;
    model_clear();

    // power-on reset
    rd("por", 5'd0, 5'd30);
    @(negedge clk);
    reset = 1'b0;
    rd("por_rel", 5'd15, 5'd31);

    // reset with random prior contents
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), {$urandom, $urandom});
    end
    rd("rand_pre", 5'd9, 5'd30);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      rd("rst_all", 5'(i), 5'(i));
    end
    @(negedge clk);
    reset = 1'b0;

    // write/read sweep
    for (int i = 0; i < 31; i++) begin
      wr(5'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
    end
    for (int i = 0; i < 31; i++) begin
      rd("sweep", 5'(i), 5'(30 - i));
    end
    rd("sweep_xzr", 5'd31, 5'd31);

    // zero register write is discarded
    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 32; i++) begin
      rd("xzr_wr", 5'(i), 5'd31);
    end

    // write disable
    @(negedge clk);
    reg_write      = 1'b0;
    write_register = 5'd5;
    write_data     = 64'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rd("wr_dis", 5'd5, 5'd5);

    // same-cycle hazard on X7
    wr(5'd7, 64'h1111);
    @(negedge clk);
    reg_write      = 1'b1;
    write_register = 5'd7;
    write_data     = 64'h2222;
    read_register1 = 5'd7;
    read_register2 = 5'd7;
`ifdef REG_FILE_BYPASS_EN
    model[7] = 64'h2222;
`endif
    push_pair(5'd7, 5'd7);
    #1;
    cmp("hz_pre_p1", read_data1);
    cmp("hz_pre_p2", read_data2);
    @(posedge clk);
    #1;
    model_wr(5'd7, 64'h2222);
    push_pair(5'd7, 5'd7);
    cmp("hz_post_p1", read_data1);
    cmp("hz_post_p2", read_data2);
    reg_write = 1'b0;

    // X31 read during X31 write
    @(negedge clk);
    reg_write      = 1'b1;
    write_register = 5'd31;
    write_data     = 64'h5A5A;
    read_register1 = 5'd31;
    read_register2 = 5'd31;
    push_pair(5'd31, 5'd31);
    #1;
    cmp("xzr_live_p1", read_data1);
    cmp("xzr_live_p2", read_data2);
    @(posedge clk);
    #1;
    reg_write = 1'b0;

    // async reset between edges
    wr(5'd3, 64'h1234);
    @(negedge clk);
    read_register1 = 5'd3;
    read_register2 = 5'd3;
    push_pair(5'd3, 5'd3);
    #1;
    cmp("ar_pre_p1", read_data1);
    cmp("ar_pre_p2", read_data2);
    #1;
    reset = 1'b1;
    model_clear();
    push_pair(5'd3, 5'd3);
    #1;
    cmp("ar_drop_p1", read_data1);
    cmp("ar_drop_p2", read_data2);

    // write during reset is lost
    wr(5'd3, 64'h5555);
    rd("ar_lost", 5'd3, 5'd3);
    @(negedge clk);
    reset = 1'b0;
    rd("ar_rel", 5'd3, 5'd7);
    wr(5'd3, 64'h77);
    rd("ar_resume", 5'd3, 5'd31);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
# reg_file

32-entry × WIDTH-bit general-purpose register file for the five-stage pipeline CPU. It sits in the decode (ID) stage and consumes the one-hot register-select word produced by the 5-to-32 write decoder, driven from the writeback (WB) stage's destination address and write enable. It supplies two combinational read ports to the ID/EX pipeline register. Register 31 is the architectural zero register (XZR).

## Interface
- WIDTH, 64, data width of every register and of all data ports.
- clk  input  1  pipeline clock; all register updates occur on the rising edge.
- reset  input  1  asynchronous, active-high; clears every register while asserted.
- reg_write  input  1  write enable from WB.
- write_register  input  5  destination register number from WB.
- write_data  input  WIDTH  data to be written.
- read_register1  input  5  source register number, port 1 (Rn).
- read_register2  input  5  source register number, port 2 (Rm/Rd).
- read_data1  output  WIDTH  contents of read_register1.
- read_data2  output  WIDTH  contents of read_register2.

## Operation
- Storage: 31 writable registers X0–X30, each WIDTH flip-flops with a load-enable. X31 has no storage and reads as 0.
- Write select: write_register plus reg_write produce a 32-bit one-hot enable word (5-to-32 decode, gated by reg_write). Bit 31 is ignored.
- Write: on a rising clk edge with reg_write=1 and write_register≠31, Xn takes write_data. All other registers hold.
- Write to X31: discarded with no side effect. Reading X31 afterwards still returns 0.
- reg_write=0: no register changes, whatever the value of write_register.
- Read: each port is a 32:1 × WIDTH mux selected by its read_register. The ports are independent. Both ports may address the same register.
- Reset: while reset=1, X0–X30 are forced to 0 asynchronously, and any write at a concurrent clk edge is lost. Writes resume at the first rising edge after reset deasserts.

## Timing
- Reset value of all outputs: read_data1 = read_data2 = 0. Every register is 0 during and immediately after reset.
- Write latency: one edge. Data presented in cycle N is readable (non-bypassed) from just after edge N.
- Read latency: combinational. The path is read_register → mux → read_data, with no clock involved.
- Same-cycle read/write of the same register (write_register = read_registerK, reg_write=1, register≠31): behaviour depends on REG_FILE_BYPASS_EN (see Configuration).
- Simultaneous reads of X31 with a write to X31: both return 0.
- Reset asserted mid-cycle after a write edge: the register clears at once, and the read ports show 0 within the combinational delay.

## Configuration
- Macro: REG_FILE_BYPASS_EN.
- Defined: internal write-through forwarding. When reg_write=1, write_register≠31 and write_register equals read_registerK, read_dataK = write_data combinationally in the same cycle. This removes the WB→ID hazard without an extra forwarding path.
- Undefined: no forwarding. read_dataK shows the pre-edge register contents until the write edge. The hazard unit must then stall or forward externally for one cycle.
- X31 always reads 0 in both builds. Bypass never applies to X31.

## Test plan
- Reset: assert reset with random prior contents, then read all 32 registers on both ports -> every read returns 0.
- Write/read sweep: for i=0..30 write 64'hA5A5_0000_0000_0000+i, then read Xi on port 1 and X(30-i) on port 2 -> values match. X31 reads 0.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to X31 with reg_write=1 -> X31 reads 0 and no other register changes.
- Write disable: reg_write=0, write_register=5, write_data=64'hDEAD_BEEF -> X5 keeps its prior value.
- Same-cycle hazard: X7=64'h1111, then in one cycle write 64'h2222 to X7 and read X7 on both ports. With REG_FILE_BYPASS_EN -> 64'h2222 before the edge. Without it -> 64'h1111 before the edge and 64'h2222 after it.
- Async reset mid-run: after writing X3=64'h1234, assert reset between edges -> read_data for X3 drops to 0 without a clock edge. A write on an edge during reset is lost.
